// File: rtl/axi_sram_bridge.sv
// axi_sram_bridge: AXI3 slave serialising INCR/FIXED bursts onto one synchronous single-port SRAM
// Define SRAM_BRIDGE_DECERR_EN to answer out-of-range start addresses with DECERR instead of aliasing
module axi_sram_bridge #(
  parameter int          ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          RD_FIRST  = 1'b1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
  localparam logic [2:0] IDLE = 3'd0, RD_ADDR = 3'd1, RD_DATA = 3'd2, WR_DATA = 3'd3, WR_RESP = 3'd4;
  logic [2:0] state;
  logic prio;
  logic [31:0] addr, off, next_addr, start, rdata_q;
  logic [3:0] id, len, beat;
  logic [2:0] size;
  logic [1:0] burst;
  logic err, fresh, rd_go, wr_go, start_err, w_fire, unused;
  assign rd_go = state == IDLE && arvalid && (!awvalid || prio);
  assign wr_go = state == IDLE && awvalid && !rd_go;
  assign arready = rd_go;
  assign awready = wr_go;
  assign start = rd_go ? araddr : awaddr;
`ifdef SRAM_BRIDGE_DECERR_EN
  assign start_err = |((start - BASE_ADDR) >> (ADDR_W + 2));
`else
  assign start_err = 1'b0;
`endif
  assign off = addr - BASE_ADDR;
  assign next_addr = burst == 2'b00 ? addr : addr + (32'd1 << size);
  assign sram_addr = off[ADDR_W+1:2];
  assign wready = state == WR_DATA;
  assign w_fire = wready && wvalid && !err;
  assign sram_en = state == RD_ADDR || w_fire;
  assign sram_we = w_fire ? wstrb : 4'h0;
  assign sram_wdata = wdata;
  // SRAM data arrives in the first RD_DATA cycle; pass it through, then serve the held copy
  assign rdata = fresh ? sram_rdata : rdata_q;
  assign unused = ^{wid, wlast, off};
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      prio <= RD_FIRST;
      addr <= '0;
      id <= '0;
      len <= '0;
      beat <= '0;
      size <= '0;
      burst <= '0;
      err <= 1'b0;
      fresh <= 1'b0;
      rdata_q <= '0;
      rvalid <= 1'b0;
      rlast <= 1'b0;
      rid <= '0;
      rresp <= '0;
      bvalid <= 1'b0;
      bid <= '0;
      bresp <= '0;
    end else begin
      case (state)
        IDLE: if (rd_go || wr_go) begin
          id <= rd_go ? arid : awid;
          addr <= start;
          len <= rd_go ? arlen : awlen;
          size <= rd_go ? arsize : awsize;
          burst <= rd_go ? arburst : awburst;
          beat <= '0;
          err <= start_err;
          if (arvalid && awvalid) prio <= !prio;
          state <= wr_go ? WR_DATA : start_err ? RD_DATA : RD_ADDR;
          if (rd_go && start_err) begin
            rvalid <= 1'b1;
            rlast <= arlen == 4'd0;
            rid <= arid;
            rresp <= 2'b11;
            rdata_q <= '0;
          end
        end
        RD_ADDR: begin
          state <= RD_DATA;
          rvalid <= 1'b1;
          rlast <= beat == len;
          rid <= id;
          rresp <= 2'b00;
          fresh <= 1'b1;
        end
        RD_DATA: begin
          if (fresh) begin
            rdata_q <= sram_rdata;
            fresh <= 1'b0;
          end
          if (rready) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast <= 1'b0;
              state <= IDLE;
            end else begin
              addr <= next_addr;
              beat <= beat + 4'd1;
              rlast <= err && beat + 4'd1 == len;
              rvalid <= err;
              state <= err ? RD_DATA : RD_ADDR;
            end
          end
        end
        WR_DATA: if (wvalid) begin
          addr <= next_addr;
          beat <= beat + 4'd1;
          if (beat == len) begin
            state <= WR_RESP;
            bvalid <= 1'b1;
            bid <= id;
            bresp <= {2{err}};
          end
        end
        WR_RESP: if (bready) begin
          bvalid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_sram_bridge.sv
// tb_axi_sram_bridge: randomized AXI master against a word-array reference model of the bridge
module tb_axi_sram_bridge;
  localparam int ADDR_W = 6, DEPTH = 64;
  localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef SRAM_BRIDGE_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [3:0] awid = '0, arid = '0, wid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata, sram_wdata, sram_rdata;
  logic [3:0] awlen = '0, arlen = '0, wstrb = '0, sram_we;
  logic [2:0] awsize = '0, arsize = '0;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  logic awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, rready = 1'b0;
  logic awready, arready, wready, bvalid, rlast, rvalid, sram_en;
  logic [ADDR_W-1:0] sram_addr;

  axi_sram_bridge #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 aclk = ~aclk;

  typedef struct {logic [3:0] id; logic [31:0] data; logic last; logic [1:0] resp;} rbeat_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;
  rbeat_t rq[$];
  bexp_t bq[$];
  logic [31:0] smem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int n_chk = 0, n_fail = 0, n_en = 0, n_rbeat = 0;
  logic [31:0] last_rdata;
  logic [3:0] last_rid, last_bid;
  logic [1:0] last_rresp, last_bresp;
  logic last_rlast;
  logic [3:0] t_id, t_len;
  logic [31:0] t_addr;
  logic [2:0] t_size;
  logic [1:0] t_burst;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic is_err(input logic [31:0] a);
    return DECERR && (a < BASE || 64'(a) >= 64'(BASE) + 64'(4 * DEPTH));
  endfunction
  function automatic int wi(input logic [31:0] a);
    return int'(((a - BASE) / 4) % DEPTH);
  endfunction
  function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
    return b == 2'b00 ? a : a + 32'(2 ** int'(s));
  endfunction

  // synchronous single-port SRAM seen by the bridge
  always @(posedge aclk)
    if (sram_en) begin
      if (sram_we == 4'h0) sram_rdata <= smem[sram_addr];
      else for (int j = 0; j < 4; j++) if (sram_we[j]) smem[sram_addr][8*j +: 8] <= sram_wdata[8*j +: 8];
    end

  always @(posedge aclk) if (aresetn && sram_en) n_en++;

  always @(negedge aclk)
    if (aresetn) begin
      chk("ready_excl", 64'(arready & awready), 64'd0);
      if (rvalid) begin
        if (rq.size() == 0) chk("r_spurious", rvalid, 0);
        else begin
          chk("rid", rid, rq[0].id);
          chk("rdata", rdata, rq[0].data);
          chk("rresp", rresp, rq[0].resp);
          chk("rlast", rlast, rq[0].last);
          if (rready) begin
            last_rdata = rdata; last_rid = rid; last_rresp = rresp; last_rlast = rlast;
            n_rbeat++;
            rq.delete(0);
          end
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) chk("b_spurious", bvalid, 0);
        else begin
          chk("bid", bid, bq[0].id);
          chk("bresp", bresp, bq[0].resp);
          if (bready) begin
            last_bid = bid; last_bresp = bresp;
            bq.delete(0);
          end
        end
      end
    end

  task automatic raise_ar(input logic [3:0] i, input logic [31:0] a, input logic [3:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    logic [31:0] x;
    logic e;
    rbeat_t eb;
    x = a; e = is_err(a);
    arid = i; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    for (int k = 0; k <= int'(l); k++) begin
      eb.id = i; eb.data = e ? 32'h0 : ref_mem[wi(x)]; eb.last = k == int'(l); eb.resp = e ? 2'b11 : 2'b00;
      rq.push_back(eb);
      x = nxt(x, s, b);
    end
  endtask

  task automatic raise_aw(input logic [3:0] i, input logic [31:0] a, input logic [3:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    awid = i; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
    t_id = i; t_addr = a; t_len = l; t_size = s; t_burst = b;
  endtask

  task automatic wait_ar;
    int to = 0;
    do begin @(negedge aclk); to++; end while (!arready && to < 200);
    chk("ar_handshake", arready, 1);
    @(posedge aclk); #1 arvalid = 1'b0;
  endtask

  task automatic wait_aw;
    int to = 0;
    do begin @(negedge aclk); to++; end while (!awready && to < 200);
    chk("aw_handshake", awready, 1);
    @(posedge aclk); #1 awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [31:0] d0, input logic [3:0] s0, input bit rnd);
    logic [31:0] x, d;
    logic [3:0] s;
    logic e;
    bexp_t be;
    int to;
    x = t_addr; e = is_err(t_addr);
    for (int k = 0; k <= int'(t_len); k++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      d = rnd ? $urandom : d0 + 32'(k) * 32'h0101_0101;
      s = rnd ? 4'($urandom) : s0;
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = k == int'(t_len);
      to = 0;
      do begin @(negedge aclk); to++; end while (!wready && to < 200);
      chk("w_handshake", wready, 1);
      @(posedge aclk); #1 wvalid = 1'b0; wlast = 1'b0;
      if (!e) for (int j = 0; j < 4; j++) if (s[j]) ref_mem[wi(x)][8*j +: 8] = d[8*j +: 8];
      x = nxt(x, t_size, t_burst);
    end
    be.id = t_id; be.resp = e ? 2'b11 : 2'b00;
    bq.push_back(be);
  endtask

  task automatic b_phase(input bit rnd);
    int to = 0;
    bit done = 0;
    do begin
      bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk); done = bvalid && bready; to++;
      if (!done) begin @(posedge aclk); #1; end
    end while (!done && to < 200);
    chk("b_done", done, 1);
    @(posedge aclk); #1 bready = 1'b0;
  endtask

  task automatic r_phase(input int mode);
    int to = 0;
    bit done = 0;
    do begin
      rready = mode == 2 ? 1'b1 : mode == 1 ? (to % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge aclk); done = rvalid && rready && rlast; to++;
      if (!done) begin @(posedge aclk); #1; end
    end while (!done && to < 400);
    chk("r_done", done, 1);
    @(posedge aclk); #1 rready = 1'b0;
  endtask

  task automatic do_reset;
    aresetn = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    rq.delete(); bq.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  int to, en0, rb0;
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom;
      smem[i] <= v;
      ref_mem[i] = v;
    end
    do_reset;
    @(negedge aclk);
    chk("rst_arready", arready, 0); chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0); chk("rst_bvalid", bvalid, 0); chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_we", sram_we, 0); chk("rst_rdata", rdata, 0); chk("rst_rlast", rlast, 0);
    chk("rst_bid", bid, 0); chk("rst_rid", rid, 0); chk("rst_bresp", bresp, 0); chk("rst_rresp", rresp, 0);
    @(posedge aclk); #1;
    // single write then read back
    raise_aw(4'd3, BASE + 32'h10, 4'd0, 3'd2, 2'b01); wait_aw;
    w_phase(32'hDEAD_BEEF, 4'hF, 0); b_phase(0);
    chk("t1_bid", last_bid, 3); chk("t1_bresp", last_bresp, 0);
    raise_ar(4'd5, BASE + 32'h10, 4'd0, 3'd2, 2'b01); wait_ar; r_phase(2);
    chk("t1_rdata", last_rdata, 32'hDEAD_BEEF); chk("t1_rid", last_rid, 5); chk("t1_rlast", last_rlast, 1);
    // four-beat INCR burst, read back with rready toggling
    raise_aw(4'd1, BASE, 4'd3, 3'd2, 2'b01); wait_aw;
    w_phase(32'hA0A0_A000, 4'hF, 0); b_phase(0);
    rb0 = n_rbeat;
    raise_ar(4'd2, BASE, 4'd3, 3'd2, 2'b01); wait_ar; r_phase(1);
    chk("t2_beats", n_rbeat - rb0, 4); chk("t2_last_word", last_rdata, 32'hA3A3_A303);
    // one past the top of the SRAM window
    en0 = n_en;
    raise_ar(4'd7, BASE + 32'(4 * DEPTH), 4'd1, 3'd2, 2'b01); wait_ar; r_phase(2);
    if (DECERR) begin
      chk("t6_rdata", last_rdata, 0); chk("t6_rresp", last_rresp, 3); chk("t6_en", n_en - en0, 0);
    end else begin
      chk("t6_rdata", last_rdata, 32'hA1A1_A101); chk("t6_rresp", last_rresp, 0); chk("t6_en", n_en - en0, 2);
    end
    // byte strobes and FIXED burst
    raise_aw(4'd2, BASE + 32'h20, 4'd0, 3'd2, 2'b01); wait_aw; w_phase(32'hFFFF_FFFF, 4'hF, 0); b_phase(0);
    raise_aw(4'd2, BASE + 32'h20, 4'd0, 3'd2, 2'b01); wait_aw; w_phase(32'h1122_3344, 4'b0101, 0); b_phase(0);
    raise_ar(4'd6, BASE + 32'h20, 4'd0, 3'd2, 2'b01); wait_ar; r_phase(2);
    chk("t4_strobe", last_rdata, 32'hFF22_FF44);
    raise_aw(4'd4, BASE + 32'h24, 4'd1, 3'd2, 2'b00); wait_aw; w_phase(32'h1234_5678, 4'hF, 0); b_phase(0);
    raise_ar(4'd6, BASE + 32'h24, 4'd0, 3'd2, 2'b01); wait_ar; r_phase(2);
    chk("t4_fixed", last_rdata, 32'h1335_5779);
    // arbitration ties after reset: read first, then write wins the next tie
    do_reset;
    raise_ar(4'd9, BASE + 32'h40, 4'd0, 3'd2, 2'b01);
    raise_aw(4'd10, BASE + 32'h44, 4'd0, 3'd2, 2'b01);
    @(negedge aclk);
    chk("tie1_arready", arready, 1); chk("tie1_awready", awready, 0);
    @(posedge aclk); #1 arvalid = 1'b0;
    r_phase(2);
    wait_aw; w_phase(32'h5555_0000, 4'hF, 0); b_phase(0);
    raise_ar(4'd11, BASE + 32'h48, 4'd0, 3'd2, 2'b01);
    raise_aw(4'd12, BASE + 32'h4C, 4'd0, 3'd2, 2'b01);
    @(negedge aclk);
    chk("tie2_awready", awready, 1); chk("tie2_arready", arready, 0);
    @(posedge aclk); #1 awvalid = 1'b0;
    w_phase(32'h6666_0000, 4'hF, 0); b_phase(0);
    wait_ar; r_phase(2);
    chk("tie2_rid", last_rid, 11);
    // async reset while a read beat is pending
    rready = 1'b0;
    raise_ar(4'd13, BASE + 32'h10, 4'd2, 3'd2, 2'b01); wait_ar;
    to = 0;
    do begin @(negedge aclk); to++; end while (!rvalid && to < 20);
    chk("t5_rvalid_before", rvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("t5_rvalid_reset", rvalid, 0); chk("t5_en_reset", sram_en, 0);
    arvalid = 1'b0;
    rq.delete();
    @(posedge aclk); #1 aresetn = 1'b1;
    raise_ar(4'd14, BASE + 32'h10, 4'd0, 3'd2, 2'b01); wait_ar; r_phase(2);
    chk("t5_rdata", last_rdata, 32'hDEAD_BEEF); chk("t5_rid", last_rid, 14);
    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int pick;
      pick = $urandom_range(0, 9);
      a = pick < 7 ? BASE + $urandom_range(0, 255) : pick == 7 ? $urandom :
          pick == 8 ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : BASE - 32'd4;
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      if ($urandom_range(0, 1) == 1) begin
        raise_aw(4'($urandom), a, 4'($urandom), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
        wait_aw; w_phase(32'h0, 4'h0, 1); b_phase(1);
      end else begin
        raise_ar(4'($urandom), a, 4'($urandom), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
        wait_ar; r_phase(0);
      end
    end
    repeat (4) @(posedge aclk);
    chk("rq_drained", rq.size(), 0); chk("bq_drained", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
